// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: occupancy encoding for pipeline latches
// and the packed inter-stage bundles they carry.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } pipe_occ_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [3:0]  alu_op;
        logic        we;
        logic [11:0] imm;
    } id_ex_t;

    localparam int ID_EX_W = $bits(id_ex_t);

endpackage

// File: rtl/pipe_skid_latch_sat_counter.sv
// Saturating up-counter with a 0..3 increment per cycle.
// Synchronous active-high reset; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc_en,
    input  logic [1:0]   inc_amt,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic [W+1:0] sum;

    always_comb begin
        sum     = {2'b00, count_q} + {{W{1'b0}}, inc_amt};
        count_d = count_q;
        if (inc_en) begin
            // Clamp at the all-ones value so the count never wraps.
            if (sum > {2'b00, {W{1'b1}}}) begin
                count_d = {W{1'b1}};
            end else begin
                count_d = sum[W-1:0];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_skid_latch.sv
// Generic pipeline register with a 2-entry skid buffer: upstream ready
// comes from a flop, with flush, hold and saturating stall/drop counters.
module pipe_skid_latch
    import cpu_types_pkg::*;
#(
    parameter int                DATA_W         = 32,
    parameter logic [DATA_W-1:0] RST_VAL        = '0,
    parameter bit                CLEAR_ON_FLUSH = 1'b1,
    parameter int                CNT_W          = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              hold,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    pipe_occ_t         occ_q;
    pipe_occ_t         occ_d;
    logic [DATA_W-1:0] m_data_q;
    logic [DATA_W-1:0] m_data_d;
    logic [DATA_W-1:0] s_data_q;
    logic [DATA_W-1:0] s_data_d;

    logic       m_valid;
    logic       s_valid;
    logic       accept;
    logic       fire;
    logic       stall_en;
    logic [1:0] drop_amt;

    assign m_valid = (occ_q != OCC_EMPTY);
    assign s_valid = (occ_q == OCC_TWO);

    // Only hold and RST are combinational; s_valid is a decode of a flop.
    assign in_ready  = !s_valid && !hold && !RST;
    assign accept    = in_valid && in_ready;
    assign fire      = m_valid && out_ready;
    assign out_valid = m_valid;
    assign out_data  = m_data_q;
    assign occupancy = occ_q;

    always_comb begin
        occ_d    = occ_q;
        m_data_d = m_data_q;
        s_data_d = s_data_q;
        if (flush) begin
            occ_d = OCC_EMPTY;
            if (CLEAR_ON_FLUSH) begin
                m_data_d = RST_VAL;
                s_data_d = RST_VAL;
            end
        end else begin
            unique case (occ_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        occ_d    = OCC_ONE;
                        m_data_d = in_data;
                    end
                end
                OCC_ONE: begin
                    if (accept && fire) begin
                        m_data_d = in_data;
                    end else if (accept) begin
                        occ_d    = OCC_TWO;
                        s_data_d = in_data;
                    end else if (fire) begin
                        occ_d = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (fire) begin
                        occ_d    = OCC_ONE;
                        m_data_d = s_data_q;
                    end
                end
                default: occ_d = OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            occ_q    <= OCC_EMPTY;
            m_data_q <= RST_VAL;
            s_data_q <= RST_VAL;
        end else begin
            occ_q    <= occ_d;
            m_data_q <= m_data_d;
            s_data_q <= s_data_d;
        end
    end

    // A fire in the flush cycle is delivered, so it is not a drop.
    assign drop_amt = occupancy - {1'b0, fire} + {1'b0, accept};
    assign stall_en = m_valid && !out_ready && !flush;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK     (CLK),
        .RST     (RST),
        .inc_en  (stall_en),
        .inc_amt (2'd1),
        .count   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_drop_cnt (
        .CLK     (CLK),
        .RST     (RST),
        .inc_en  (flush),
        .inc_amt (drop_amt),
        .count   (drop_cnt)
    );

endmodule

// File: tb/tb_pipe_skid_latch.sv
// Bench for pipe_skid_latch: directed scenarios plus random traffic
// checked against a queue-based model of the latch.
module tb_pipe_skid_latch;

    logic        CLK = 1'b0;
    logic        RST;
    logic        flush;
    logic        hold;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;
    logic [15:0] drop_cnt;

    logic        in_ready2;
    logic        out_valid2;
    logic [31:0] out_data2;
    logic [1:0]  occupancy2;
    logic [1:0]  stall_cnt2;
    logic [1:0]  drop_cnt2;

    int total = 0;
    int bad   = 0;

    logic [31:0] mq[$];
    longint      st_raw;
    longint      dr_raw;
    bit          clr;

    always #5 CLK = ~CLK;

    pipe_skid_latch #(.DATA_W(32), .CNT_W(16)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .flush     (flush),
        .hold      (hold),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt),
        .drop_cnt  (drop_cnt)
    );

    pipe_skid_latch #(.DATA_W(32), .CNT_W(2)) dut2 (
        .CLK       (CLK),
        .RST       (RST),
        .flush     (flush),
        .hold      (hold),
        .in_valid  (in_valid),
        .in_ready  (in_ready2),
        .in_data   (in_data),
        .out_valid (out_valid2),
        .out_ready (out_ready),
        .out_data  (out_data2),
        .occupancy (occupancy2),
        .stall_cnt (stall_cnt2),
        .drop_cnt  (drop_cnt2)
    );

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic apply(input logic r, input logic f, input logic h,
                         input logic iv, input logic [31:0] d,
                         input logic ordy);
        @(negedge CLK);
        RST       = r;
        flush     = f;
        hold      = h;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
    endtask

    // Model: a FIFO of at most two entries; counters kept unbounded
    // and clamped when compared.
    task automatic tick();
        int n;
        bit acc;
        bit fir;
        n   = mq.size();
        acc = in_valid && (n < 2) && !hold && !RST;
        fir = (n > 0) && out_ready;
        if (RST) begin
            mq.delete();
            st_raw = 0;
            dr_raw = 0;
            clr    = 1'b1;
        end else if (flush) begin
            dr_raw += n - int'(fir) + int'(acc);
            mq.delete();
            clr = 1'b1;
        end else begin
            if (n > 0 && !out_ready) st_raw++;
            if (fir) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(in_data);
                clr = 1'b0;
            end
        end
        @(posedge CLK);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            apply(1, 0, 0, 1, 32'hDEAD, 0);
            total++;
            if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL rst_ready got=%b want=0", in_ready);
            end
            tick();
        end
        apply(0, 0, 0, 0, 32'h0, 0);
        total++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || occupancy !== 2'd0) begin
            bad++;
            $display("FAIL rst_state got v=%b d=%h occ=%0d want v=0 d=0 occ=0",
                     out_valid, out_data, occupancy);
        end
        total++;
        if (stall_cnt !== 16'd0 || drop_cnt !== 16'd0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_cnt got st=%0d dr=%0d rdy=%b want 0 0 1",
                     stall_cnt, drop_cnt, in_ready);
        end
        tick();
    endtask

    task automatic test_stream();
        for (int k = 1; k <= 9; k++) begin
            apply(0, 0, 0, (k <= 8), 32'(k), 1);
            if (k >= 2) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== 32'(k - 1)) begin
                    bad++;
                    $display("FAIL stream k=%0d got v=%b d=%h want v=1 d=%h",
                             k, out_valid, out_data, 32'(k - 1));
                end
            end
            total++;
            if (occupancy > 2'd1 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL stream_occ k=%0d got occ=%0d rdy=%b want <=1 1",
                         k, occupancy, in_ready);
            end
            tick();
        end
    endtask

    task automatic test_skid();
        apply(0, 0, 0, 0, 32'h0, 1);
        tick();
        apply(0, 0, 0, 1, 32'h11, 0);
        tick();
        apply(0, 0, 0, 1, 32'h22, 0);
        total++;
        if (in_ready !== 1'b1 || occupancy !== 2'd1) begin
            bad++;
            $display("FAIL skid_one got rdy=%b occ=%0d want 1 1", in_ready, occupancy);
        end
        tick();
        apply(0, 0, 0, 1, 32'h33, 0);
        total++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'h11) begin
            bad++;
            $display("FAIL skid_two got occ=%0d rdy=%b d=%h want 2 0 11",
                     occupancy, in_ready, out_data);
        end
        tick();
        apply(0, 0, 0, 0, 32'h0, 1);
        total++;
        if (stall_cnt !== 16'(sat(st_raw, 16)) || in_ready !== 1'b0 ||
            out_data !== 32'h11) begin
            bad++;
            $display("FAIL skid_stall got st=%0d rdy=%b d=%h want %0d 0 11",
                     stall_cnt, in_ready, out_data, sat(st_raw, 16));
        end
        tick();
        apply(0, 0, 0, 0, 32'h0, 1);
        total++;
        if (out_data !== 32'h22 || in_ready !== 1'b1 || occupancy !== 2'd1) begin
            bad++;
            $display("FAIL skid_drain got d=%h rdy=%b occ=%0d want 22 1 1",
                     out_data, in_ready, occupancy);
        end
        tick();
        apply(0, 0, 0, 0, 32'h0, 1);
        total++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL skid_empty got occ=%0d v=%b want 0 0", occupancy, out_valid);
        end
        tick();
    endtask

    task automatic test_flush();
        longint d0;
        apply(0, 0, 0, 1, 32'hA, 0);
        tick();
        apply(0, 0, 0, 1, 32'hB, 0);
        tick();
        d0 = dr_raw;
        apply(0, 1, 0, 1, 32'hC, 1);
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'hA) begin
            bad++;
            $display("FAIL flush_fire got v=%b d=%h want 1 a", out_valid, out_data);
        end
        tick();
        apply(0, 0, 0, 1, 32'hD, 0);
        total++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== 32'h0 ||
            drop_cnt !== 16'(d0 + 1)) begin
            bad++;
            $display("FAIL flush_two got occ=%0d v=%b d=%h dr=%0d want 0 0 0 %0d",
                     occupancy, out_valid, out_data, drop_cnt, d0 + 1);
        end
        tick();
        apply(0, 1, 0, 1, 32'hE, 0);
        tick();
        apply(0, 0, 0, 0, 32'h0, 0);
        total++;
        if (occupancy !== 2'd0 || out_data !== 32'h0 || drop_cnt !== 16'(d0 + 3)) begin
            bad++;
            $display("FAIL flush_acc got occ=%0d d=%h dr=%0d want 0 0 %0d",
                     occupancy, out_data, drop_cnt, d0 + 3);
        end
        tick();
    endtask

    task automatic test_hold();
        apply(0, 0, 0, 1, 32'h55, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 1, 1, 32'h66, 1);
            total++;
            if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold_rdy i=%0d got=%b want=0", i, in_ready);
            end
            tick();
        end
        apply(0, 0, 0, 1, 32'h66, 1);
        total++;
        if (in_ready !== 1'b1 || occupancy !== 2'd0) begin
            bad++;
            $display("FAIL hold_rel got rdy=%b occ=%0d want 1 0", in_ready, occupancy);
        end
        tick();
        apply(0, 0, 0, 0, 32'h0, 0);
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'h66) begin
            bad++;
            $display("FAIL hold_acc got v=%b d=%h want 1 66", out_valid, out_data);
        end
        tick();
    endtask

    task automatic test_sat();
        apply(1, 0, 0, 0, 32'h0, 0);
        tick();
        apply(0, 0, 0, 1, 32'h77, 0);
        tick();
        for (int i = 0; i <= 6; i++) begin
            apply(0, 0, 0, 0, 32'h0, 0);
            total++;
            if (stall_cnt2 !== 2'((i > 3) ? 3 : i) || stall_cnt !== 16'(i)) begin
                bad++;
                $display("FAIL sat i=%0d got s2=%0d s16=%0d want %0d %0d",
                         i, stall_cnt2, stall_cnt, (i > 3) ? 3 : i, i);
            end
            tick();
        end
    endtask

    task automatic test_random();
        bit exp_rdy;
        for (int c = 0; c < 400; c++) begin
            apply(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 7) == 0),
                  $urandom_range(0, 1),
                  $urandom,
                  ($urandom_range(0, 2) != 0));
            exp_rdy = (mq.size() < 2) && !hold && !RST;
            total++;
            if (in_ready !== exp_rdy || out_valid !== (mq.size() > 0) ||
                occupancy !== 2'(mq.size())) begin
                bad++;
                $display("FAIL rnd_ctl c=%0d got rdy=%b v=%b occ=%0d want %b %b %0d",
                         c, in_ready, out_valid, occupancy, exp_rdy,
                         mq.size() > 0, mq.size());
            end
            total++;
            if ((mq.size() > 0 && out_data !== mq[0]) ||
                (mq.size() == 0 && clr && out_data !== 32'h0)) begin
                bad++;
                $display("FAIL rnd_data c=%0d got=%h want=%h", c, out_data,
                         (mq.size() > 0) ? mq[0] : 32'h0);
            end
            total++;
            if (stall_cnt !== 16'(sat(st_raw, 16)) || drop_cnt !== 16'(sat(dr_raw, 16)) ||
                stall_cnt2 !== 2'(sat(st_raw, 2)) || drop_cnt2 !== 2'(sat(dr_raw, 2))) begin
                bad++;
                $display("FAIL rnd_cnt c=%0d got st=%0d dr=%0d s2=%0d d2=%0d want %0d %0d %0d %0d",
                         c, stall_cnt, drop_cnt, stall_cnt2, drop_cnt2,
                         sat(st_raw, 16), sat(dr_raw, 16), sat(st_raw, 2), sat(dr_raw, 2));
            end
            tick();
        end
    endtask

    initial begin
        RST       = 1'b1;
        flush     = 1'b0;
        hold      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        st_raw    = 0;
        dr_raw    = 0;
        clr       = 1'b1;
        test_reset();
        test_stream();
        test_skid();
        test_flush();
        test_hold();
        test_sat();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
